vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA timing and pixel-pipeline generator. It is the successor to the fixed 640x480 sync block, and adds the following:
- configurable timings, sync polarity and colour widths
- a clock enable
- pixel coordinate requests to the image source
- frame/line strobes and a frame counter
- blanking of colour outside the visible area

It sits between the board/game image logic (ROM/renderer) and the VGA pins.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync pulse width (cycles)
H_BP, 48, horizontal back porch (cycles)
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
R_W, 3, red bits
G_W, 3, green bits
B_W, 2, blue bits
Derived values (not overridable):
- H_TOTAL = H_SYNC+H_BP+H_VIS+H_FP (800)
- V_TOTAL = V_SYNC+V_BP+V_VIS+V_FP (521)
- CW = R_W+G_W+B_W

Ports:
pclk  in  1  pixel clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
ce  in  1  pixel enable; the whole block advances only on cycles with ce=1
rgb_in  in  CW  colour for requested pixel, {R,G,B} MSB-first
pix_req  out  1  requested pixel (pix_x,pix_y) is visible
pix_x  out  10  requested column, 0..H_VIS-1 (0 when pix_req=0)
pix_y  out  10  requested row, 0..V_VIS-1 (0 when pix_req=0)
frame_start  out  1  one-ce-cycle strobe, stage 1, at h_cnt=0 and v_cnt=0
line_start  out  1  one-ce-cycle strobe, stage 1, whenever h_cnt=0
frame_cnt  out  8  frames completed, wraps 255->0
vgaRed  out  R_W  red to pins
vgaGreen  out  G_W  green to pins
vgaBlue  out  B_W  blue to pins
Hsync  out  1  horizontal sync to pins
Vsync  out  1  vertical sync to pins
vid_en  out  1  visible pixel on pins this cycle

Behaviour:
- Reset (async assert, sync release on pclk):
  - h_cnt=0, v_cnt=0, frame_cnt=0
  - pix_req, pix_x, pix_y, frame_start, line_start, vid_en and all colour outputs = 0
  - Hsync = ~H_POL, Vsync = ~V_POL (inactive), and all internal pipeline sync stages likewise inactive.
- Stage 0 counters:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments only on an h_cnt wrap, and wraps V_TOTAL-1 -> 0.
  - frame_cnt increments when v_cnt wraps.
- Line/frame order: sync, back porch, visible, front porch.
  - hs0 active iff h_cnt < H_SYNC; vs0 active iff v_cnt < V_SYNC.
  - vis0 iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_VIS and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_VIS.
- Stage 1 (registered from stage 0):
  - pix_req = vis0
  - pix_x = h_cnt-(H_SYNC+H_BP) and pix_y = v_cnt-(V_SYNC+V_BP) when vis0, else 0
  - frame_start, line_start; hs1, vs1 and de1 carried alongside.
- Source contract: rgb_in must hold the colour for the stage-1 coordinates during the next ce cycle, so a synchronous-read ROM addressed directly by pix_x/pix_y is legal.
- Stage 2: hs2, vs2 and de2 are delayed copies of stage 1.
- Stage 3 outputs (registered):
  - colours = rgb_in fields when de2, else 0
  - Hsync = hs2 ? H_POL : ~H_POL; Vsync likewise with V_POL
  - vid_en = de2
- Latency: counter to pins = 3 ce cycles; pix_req to matching vid_en = 2 ce cycles. Sync and colour stay exactly aligned.
- ce=0 holds every register, including strobes: a strobe lasts one ce=1 cycle, possibly spanning several pclk cycles. ce tied to 1 gives full rate.
- Widths:
  - Counters are 10 bits wide, sized for H_TOTAL and V_TOTAL <= 1024.
  - Coordinate subtraction is done at counter width, with no sign extension needed (it only occurs when vis0).
- Reset mid-frame: restarts at h_cnt=0, v_cnt=0. The first frame_start occurs on the first ce cycle after release.

Test Plan:
1. Reset with defaults -> every output at its reset value, Hsync=1, Vsync=1; first ce cycle after release -> frame_start=1, line_start=1.
2. Defaults, ce=1, run 2 frames:
   - Hsync low for 96 cycles per 800-cycle line.
   - Vsync low for 2 lines (1600 cycles) per 416800-cycle frame.
   - vid_en high for 640 cycles on each of 480 lines per frame.
   - frame_cnt=2.
3. rgb_in driven as a registered function of the previous cycle's pix_x (sync-ROM model) -> first vid_en pixel shows colour of x=0; colours are 0 whenever vid_en=0; vid_en rises exactly 2 cycles after pix_req.
4. ce toggling 1,0,1,0 -> all period counts double in pclk; frame_start high for exactly 2 pclk cycles; no counter advance on ce=0.
5. Small params (H_VIS=4, H_FP=1, H_SYNC=2, H_BP=1, V_VIS=3, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1):
   - Line = 8 cycles, frame = 48 cycles.
   - Hsync high for 2 cycles per line; pix_x sequence 0,1,2,3; pix_y 0..2.
6. Assert rst_n mid-visible line, hold 3 cycles, release -> outputs at reset values asynchronously; timing restarts from h_cnt=0 with frame_start on the first cycle after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: stage-0 counters, stage-1 pixel requests to the
// image source, stage-2 alignment with the source's read latency, stage-3 registered pins.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 29,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int R_W    = 3,
  parameter int G_W    = 3,
  parameter int B_W    = 2
) (
  input  logic                   pclk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic [R_W+G_W+B_W-1:0] rgb_in,
  output logic                   pix_req,
  output logic [9:0]             pix_x,
  output logic [9:0]             pix_y,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [7:0]             frame_cnt,
  output logic [R_W-1:0]         vgaRed,
  output logic [G_W-1:0]         vgaGreen,
  output logic [B_W-1:0]         vgaBlue,
  output logic                   Hsync,
  output logic                   Vsync,
  output logic                   vid_en
);

  localparam int CW      = R_W + G_W + B_W;
  localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int H_ORG   = H_SYNC + H_BP;
  localparam int V_ORG   = V_SYNC + V_BP;
  localparam logic [9:0] H_ORG_W = 10'(H_ORG);
  localparam logic [9:0] V_ORG_W = 10'(V_ORG);

  // Stage 0: free-running raster counters.
  logic [9:0] r_h_cnt, r_v_cnt;
  logic [7:0] r_frame_cnt;
  logic       w_h_wrap, w_v_wrap, w_hs0, w_vs0, w_vis0;

  assign w_h_wrap = (int'(r_h_cnt) == H_TOTAL - 1);
  assign w_v_wrap = (int'(r_v_cnt) == V_TOTAL - 1);
  assign w_hs0    = (int'(r_h_cnt) < H_SYNC);
  assign w_vs0    = (int'(r_v_cnt) < V_SYNC);
  assign w_vis0   = (int'(r_h_cnt) >= H_ORG) && (int'(r_h_cnt) < H_ORG + H_VIS) &&
                    (int'(r_v_cnt) >= V_ORG) && (int'(r_v_cnt) < V_ORG + V_VIS);

  // NOTE: every register uses non-blocking assignment so all stages sample the
  // previous cycle's values, which is what keeps the pipeline stages aligned.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_frame_cnt <= '0;
    end else if (ce) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        if (w_v_wrap) begin
          r_v_cnt     <= '0;
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
          r_v_cnt <= r_v_cnt + 10'd1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Stage 1: coordinate request; sync flags travel alongside (de1 is r_pix_req).
  logic       r_pix_req, r_frame_start, r_line_start, r_hs1, r_vs1;
  logic [9:0] r_pix_x, r_pix_y;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_req     <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_hs1         <= 1'b0;
      r_vs1         <= 1'b0;
    end else if (ce) begin
      r_pix_req     <= w_vis0;
      r_pix_x       <= w_vis0 ? r_h_cnt - H_ORG_W : '0;
      r_pix_y       <= w_vis0 ? r_v_cnt - V_ORG_W : '0;
      r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_line_start  <= (r_h_cnt == '0);
      r_hs1         <= w_hs0;
      r_vs1         <= w_vs0;
    end
  end

  // Stage 2 waits out the source's one-cycle read; stage 3 drives the pins.
  logic           r_hs2, r_vs2, r_de2;
  logic [R_W-1:0] r_red;
  logic [G_W-1:0] r_green;
  logic [B_W-1:0] r_blue;
  logic           r_hsync, r_vsync, r_vid_en;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs2    <= 1'b0;
      r_vs2    <= 1'b0;
      r_de2    <= 1'b0;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_hsync  <= ~H_POL;
      r_vsync  <= ~V_POL;
      r_vid_en <= 1'b0;
    end else if (ce) begin
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_de2    <= r_pix_req;
      r_red    <= r_de2 ? rgb_in[CW-1 -: R_W]  : '0;
      r_green  <= r_de2 ? rgb_in[B_W +: G_W]   : '0;
      r_blue   <= r_de2 ? rgb_in[B_W-1:0]      : '0;
      r_hsync  <= r_hs2 ? H_POL : ~H_POL;
      r_vsync  <= r_vs2 ? V_POL : ~V_POL;
      r_vid_en <= r_de2;
    end
  end

  assign pix_req     = r_pix_req;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign frame_cnt   = r_frame_cnt;
  assign vgaRed      = r_red;
  assign vgaGreen    = r_green;
  assign vgaBlue     = r_blue;
  assign Hsync       = r_hsync;
  assign Vsync       = r_vsync;
  assign vid_en      = r_vid_en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance and a tiny-raster
// instance share clock, reset and ce; a reference raster model feeds per-DUT queues.
module tb_vga_timing_gen;

  typedef struct {
    int hs, hbp, hvis, hfp, vs, vbp, vvis, vfp;
    bit hpol, vpol;
  } tim_t;
  typedef logic [10:0] pins_t;  // {Hsync, Vsync, vid_en, R, G, B}
  typedef logic [30:0] st1_t;   // {pix_req, pix_x, pix_y, frame_start, line_start, frame_cnt}

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] rgb0 = '0, rgb1 = '0;

  logic       d0_req, d0_fs, d0_ls, d0_vid, d0_hs, d0_vs;
  logic [9:0] d0_x, d0_y;
  logic [7:0] d0_fc;
  logic [2:0] d0_r, d0_g;
  logic [1:0] d0_b;
  logic       d1_req, d1_fs, d1_ls, d1_vid, d1_hs, d1_vs;
  logic [9:0] d1_x, d1_y;
  logic [7:0] d1_fc;
  logic [2:0] d1_r, d1_g;
  logic [1:0] d1_b;

  always #5 pclk = ~pclk;

  vga_timing_gen u_dut0 (
    .pclk(pclk), .rst_n(rst_n), .ce(ce), .rgb_in(rgb0),
    .pix_req(d0_req), .pix_x(d0_x), .pix_y(d0_y),
    .frame_start(d0_fs), .line_start(d0_ls), .frame_cnt(d0_fc),
    .vgaRed(d0_r), .vgaGreen(d0_g), .vgaBlue(d0_b),
    .Hsync(d0_hs), .Vsync(d0_vs), .vid_en(d0_vid)
  );

  vga_timing_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut1 (
    .pclk(pclk), .rst_n(rst_n), .ce(ce), .rgb_in(rgb1),
    .pix_req(d1_req), .pix_x(d1_x), .pix_y(d1_y),
    .frame_start(d1_fs), .line_start(d1_ls), .frame_cnt(d1_fc),
    .vgaRed(d1_r), .vgaGreen(d1_g), .vgaBlue(d1_b),
    .Hsync(d1_hs), .Vsync(d1_vs), .vid_en(d1_vid)
  );

  int    n_vec = 0;
  int    n_err = 0;
  tim_t  tm[2];
  int    h[2], v[2], fc[2];
  pins_t q0[$], q1[$];
  pins_t last_pins[2];
  st1_t  last_st1[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Synchronous-ROM image content.
  function automatic logic [7:0] rom(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] x3;
    x3 = x * 10'd3;
    return x3[7:0] ^ {y[5:0], 2'b00} ^ 8'h5A;
  endfunction

  function automatic bit is_vis(input tim_t t, input int hh, input int vv);
    return (hh >= t.hs + t.hbp) && (hh < t.hs + t.hbp + t.hvis) &&
           (vv >= t.vs + t.vbp) && (vv < t.vs + t.vbp + t.vvis);
  endfunction

  function automatic pins_t exp_pins(input tim_t t, input int hh, input int vv);
    logic hsy, vsy, vis;
    logic [9:0] x, y;
    vis = is_vis(t, hh, vv);
    hsy = (hh < t.hs) ? t.hpol : ~t.hpol;
    vsy = (vv < t.vs) ? t.vpol : ~t.vpol;
    x   = 10'(hh - t.hs - t.hbp);
    y   = 10'(vv - t.vs - t.vbp);
    return {hsy, vsy, vis, vis ? rom(x, y) : 8'h00};
  endfunction

  function automatic st1_t exp_st1(input tim_t t, input int hh, input int vv, input int fcnt);
    logic vis;
    logic [9:0] x, y;
    vis = is_vis(t, hh, vv);
    x   = vis ? 10'(hh - t.hs - t.hbp) : 10'd0;
    y   = vis ? 10'(vv - t.vs - t.vbp) : 10'd0;
    return {vis, x, y, (hh == 0) && (vv == 0), hh == 0, 8'(fcnt)};
  endfunction

  function automatic pins_t rst_pins(input tim_t t);
    return {~t.hpol, ~t.vpol, 1'b0, 8'h00};
  endfunction

  function automatic pins_t obs_pins(input int d);
    return (d == 0) ? {d0_hs, d0_vs, d0_vid, d0_r, d0_g, d0_b}
                    : {d1_hs, d1_vs, d1_vid, d1_r, d1_g, d1_b};
  endfunction

  function automatic st1_t obs_st1(input int d);
    return (d == 0) ? {d0_req, d0_x, d0_y, d0_fs, d0_ls, d0_fc}
                    : {d1_req, d1_x, d1_y, d1_fs, d1_ls, d1_fc};
  endfunction

  // Two reset entries model the stage-2/3 contents still draining after reset.
  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      h[d] = 0; v[d] = 0; fc[d] = 0;
      last_pins[d] = rst_pins(tm[d]);
      last_st1[d]  = '0;
    end
    repeat (2) begin
      q0.push_back(rst_pins(tm[0]));
      q1.push_back(rst_pins(tm[1]));
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pins0"}, obs_pins(0), rst_pins(tm[0]));
    check({tag, "_st1_0"}, obs_st1(0), '0);
    check({tag, "_pins1"}, obs_pins(1), rst_pins(tm[1]));
    check({tag, "_st1_1"}, obs_st1(1), '0);
  endtask

  // One pclk cycle: ce driven at negedge, outputs compared 1 time unit after posedge.
  task automatic tick(input bit ce_val);
    logic [9:0] px[2], py[2];
    int hh, vv, htot, vtot;
    @(negedge pclk);
    ce = ce_val;
    px[0] = d0_x; py[0] = d0_y;
    px[1] = d1_x; py[1] = d1_y;
    @(posedge pclk);
    #1;
    if (ce_val) begin
      for (int d = 0; d < 2; d++) begin
        hh = h[d]; vv = v[d];
        htot = tm[d].hs + tm[d].hbp + tm[d].hvis + tm[d].hfp;
        vtot = tm[d].vs + tm[d].vbp + tm[d].vvis + tm[d].vfp;
        if (d == 0) q0.push_back(exp_pins(tm[d], hh, vv));
        else        q1.push_back(exp_pins(tm[d], hh, vv));
        h[d] = hh + 1;
        if (h[d] == htot) begin
          h[d] = 0;
          v[d] = vv + 1;
          if (v[d] == vtot) begin
            v[d]  = 0;
            fc[d] = (fc[d] + 1) % 256;
          end
        end
        last_st1[d]  = exp_st1(tm[d], hh, vv, fc[d]);
        last_pins[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
      end
      rgb0 = rom(px[0], py[0]);
      rgb1 = rom(px[1], py[1]);
    end
    check("pins0", obs_pins(0), last_pins[0]);
    check("st1_0", obs_st1(0), last_st1[0]);
    check("pins1", obs_pins(1), last_pins[1]);
    check("st1_1", obs_st1(1), last_st1[1]);
  endtask

  initial begin
    int hs_lo, vs_lo, vid_n, hs1_hi, req_rise, vid_rise, fs_n, hs2_lo;
    hs_lo = 0; vs_lo = 0; vid_n = 0; hs1_hi = 0;
    req_rise = -1; vid_rise = -1; fs_n = 0; hs2_lo = 0;
    tm[0] = '{96, 48, 640, 16, 2, 29, 480, 10, 1'b0, 1'b0};
    tm[1] = '{2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1};

    rst_n = 1'b0;
    ce    = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check_reset("por");
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();

    // Full rate: raster through line 33, tiny raster through 550+ frames.
    for (int k = 1; k <= 26800; k++) begin
      tick(1'b1);
      if (k == 1) begin
        check("fs_first", d0_fs, 1);
        check("ls_first", d0_ls, 1);
      end
      if (k <= 800 && !d0_hs) hs_lo++;
      if (k <= 2000 && !d0_vs) vs_lo++;
      if (k <= 26400 && d0_vid) vid_n++;
      if (k <= 8 && d1_hs) hs1_hi++;
      if (d0_req && req_rise < 0) req_rise = k;
      if (d0_vid && vid_rise < 0) begin
        vid_rise = k;
        check("first_px_rgb", {d0_r, d0_g, d0_b}, rom(10'd0, 10'd0));
      end
      if (k == 96)    check("fcnt_2", d1_fc, 2);
      if (k == 12240) check("fcnt_255", d1_fc, 255);
      if (k == 12288) check("fcnt_wrap", d1_fc, 0);
    end
    check("hs_low_per_line", hs_lo, 96);
    check("vs_low_per_frame", vs_lo, 1600);
    check("vid_en_2_lines", vid_n, 1280);
    check("small_hs_high", hs1_hi, 2);
    check("req_to_vid", vid_rise - req_rise, 2);

    // Reset in the middle of a visible line, off the clock edge.
    check("pre_rst_vid", d0_vid, 1);
    #2;
    rst_n = 1'b0;
    ce    = 1'b0;
    #1;
    check_reset("async");
    repeat (3) @(posedge pclk);
    #1;
    check_reset("held");
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();

    // Half-rate ce: 1,0,1,0...
    for (int k = 1; k <= 2000; k++) begin
      tick(k[0]);
      if (d0_fs) fs_n++;
      if (k <= 1600 && !d0_hs) hs2_lo++;
      if (k == 1) check("fs_after_rst", d0_fs, 1);
    end
    check("fs_pclk_width", fs_n, 2);
    check("hs_low_half_rate", hs2_lo, 192);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
